// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with start/busy/done handshake; MUL by shift-add, DIV/REM by restoring division.
// Define ALU_SEQ_OVERFLOW_EN to add the overflow output.
module alu_seq #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       alu_control,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             div_by_zero
`ifdef ALU_SEQ_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111, OP_MUL = 4'b1000, OP_DIV = 4'b1001, OP_REM = 4'b1010;
  typedef enum logic {IDLE, EXEC} state_t;
  state_t state, state_d;
  logic [3:0] op;
  logic [WIDTH-1:0] opb, sres, fres, add_r, sub_r, dif;
  logic [2*WIDTH-1:0] p, p_step, mul_step, div_step;
  logic [WIDTH:0] sum, top;
  logic [CNT_W-1:0] cnt;
  logic is_mul, is_divrem, divz, long_op, accept, last, ge, slt;
  assign is_mul    = alu_control == OP_MUL;
  assign is_divrem = alu_control == OP_DIV || alu_control == OP_REM;
  assign divz      = is_divrem && src2 == '0;
  assign long_op   = is_mul || (is_divrem && !divz);
  assign accept    = state == IDLE && start;
  assign last      = state == EXEC && cnt == CNT_W'(1);
  assign add_r     = src1 + src2;
  assign sub_r     = src1 - src2;
  assign slt       = $signed(src1) < $signed(src2);
  // p holds {accumulator, multiplier} for MUL and {remainder, quotient} for DIV/REM
  assign sum       = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, opb} : '0);
  assign mul_step  = {sum, p[WIDTH-1:1]};
  assign top       = p[2*WIDTH-1:WIDTH-1];
  assign ge        = top >= {1'b0, opb};
  assign dif       = top[WIDTH-1:0] - opb;
  assign div_step  = {ge ? dif : top[WIDTH-1:0], p[WIDTH-2:0], ge};
  assign p_step    = op == OP_MUL ? mul_step : div_step;
  assign fres      = op == OP_REM ? p_step[2*WIDTH-1:WIDTH] : p_step[WIDTH-1:0];
  always_comb begin
    sres = alu_control == OP_AND ? src1 & src2 :
           alu_control == OP_OR  ? src1 | src2 :
           alu_control == OP_ADD ? add_r :
           alu_control == OP_SUB ? sub_r :
           alu_control == OP_SLT ? {{(WIDTH-1){1'b0}}, slt} :
           alu_control == OP_DIV ? '1 :
           alu_control == OP_REM ? src1 : '0;
    state_d = state == IDLE ? (start && long_op ? EXEC : IDLE) : (last ? IDLE : EXEC);
    busy = state == EXEC;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op          <= '0;
      opb         <= '0;
      p           <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      result      <= '0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef ALU_SEQ_OVERFLOW_EN
      overflow    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        op  <= alu_control;
        opb <= is_mul ? src1 : src2;
        p   <= {{WIDTH{1'b0}}, is_mul ? src2 : src1};
        cnt <= CNT_W'(WIDTH);
        if (!long_op) begin
          result <= sres;
          zero   <= sres == '0;
          done   <= 1'b1;
          if (is_divrem) div_by_zero <= 1'b1;
`ifdef ALU_SEQ_OVERFLOW_EN
          overflow <= alu_control == OP_ADD ? (src1[WIDTH-1] == src2[WIDTH-1]) && (add_r[WIDTH-1] != src1[WIDTH-1]) :
                      alu_control == OP_SUB ? (src1[WIDTH-1] != src2[WIDTH-1]) && (sub_r[WIDTH-1] != src1[WIDTH-1]) : 1'b0;
`endif
        end
      end else if (state == EXEC) begin
        p   <= p_step;
        cnt <= cnt - CNT_W'(1);
        if (last) begin
          result <= fres;
          zero   <= fres == '0;
          done   <= 1'b1;
          if (op != OP_MUL) div_by_zero <= 1'b0;
`ifdef ALU_SEQ_OVERFLOW_EN
          overflow <= op == OP_MUL && |p_step[2*WIDTH-1:WIDTH];
`endif
        end
      end
    end
  end
endmodule
